uart_tx_serializer: RTL and testbench

//   UART transmit serializer. Sits directly downstream of baud_generator:
//   it consumes the one-cycle baud `tick` pulse as bit-time strobe and shifts
//   out one frame per accepted byte: start, data LSB first, optional parity,

---
 rtl/uart_tx_serializer.sv | 149 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one accepted byte per handshake as start,
// LSB-first data, optional parity and stop bit(s), one bit per baud_tick.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Data goes out of shift_q[0] with a right shift per bit, which is
  // equivalent to indexing data[bit_idx] on the latched byte.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ ODD;
          state_d    = SYNC;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      SYNC: begin
        if (baud_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q != LAST_IDX) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end else if (PARITY_EN != 0) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            state_d    = IDLE;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: four parameterisations share clock,
// reset, tick and data; expected frames are queued on send and checked on the line.
module tb_uart_tx_serializer;

  typedef struct {
    int          id;
    int          nbits;
    logic [15:0] bits;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx_busy;
  logic [3:0] tx_done;
  logic [3:0] tx_line;

  int     n_checks;
  int     n_pass;
  int     ph;
  int     done_cnt[4];
  frame_t sb[$];

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx(tx_line[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx(tx_line[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .tx(tx_line[2]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .tx(tx_line[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 cycles, updated on negedge so it is stable for the posedge.
  initial begin
    ph        = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph        = (ph + 1) % 4;
      baud_tick = (ph == 0);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (tx_done[i] === 1'b1) done_cnt[i]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic frame_t mk(int id, logic [7:0] d, int pe, int odd, int stops);
    frame_t f;
    int     n;
    f.id    = id;
    f.bits  = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pe != 0) begin
      f.bits[n] = (^d) ^ (odd != 0);
      n++;
    end
    f.nbits = n + stops;
    return f;
  endfunction

  // Leaves the bench just after a tick edge, so the next tick is 3 cycles after accept.
  task automatic align();
    int w;
    w = 0;
    while (baud_tick !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    step();
  endtask

  task automatic send(input int id, input logic [7:0] d, input int pe, input int odd,
                      input int stops, input bit push);
    align();
    tx_data      = d;
    tx_valid[id] = 1'b1;
    if (push) sb.push_back(mk(id, d, pe, odd, stops));
    step();
    tx_valid[id] = 1'b0;
  endtask

  task automatic capture(input int max_wait);
    frame_t     f;
    int         w;
    logic [3:0] s;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    f = sb.pop_front();
    w = 0;
    while (tx_line[f.id] !== 1'b0 && w < max_wait) begin
      step();
      w++;
    end
    if (tx_line[f.id] !== 1'b0) begin
      check($sformatf("start_timeout_id%0d", f.id), tx_line[f.id], 0);
      return;
    end
    check($sformatf("busy_in_frame_id%0d", f.id), tx_busy[f.id], 1);
    check($sformatf("ready_in_frame_id%0d", f.id), tx_ready[f.id], 0);
    for (int k = 0; k < f.nbits; k++) begin
      s = '0;
      for (int j = 0; j < 4; j++) begin
        if (k != 0 || j != 0) step();
        s[j] = tx_line[f.id];
      end
      check($sformatf("bit%0d_id%0d", k, f.id), s, {4{f.bits[k]}});
    end
    step();
    check($sformatf("done_pulse_id%0d", f.id), tx_done[f.id], 1);
    check($sformatf("ready_after_id%0d", f.id), tx_ready[f.id], 1);
    check($sformatf("busy_after_id%0d", f.id), tx_busy[f.id], 0);
    step();
    check($sformatf("done_width_id%0d", f.id), tx_done[f.id], 0);
  endtask

  initial begin
    int lat;
    int w;
    int dc;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    tx_valid = '0;
    tx_data  = '0;
    repeat (3) step();
    check("rst_tx", tx_line, 4'hF);
    check("rst_ready", tx_ready, 4'hF);
    check("rst_busy", tx_busy, 4'h0);
    check("rst_done", tx_done, 4'h0);
    rst = 1'b1;
    step();

    // Default frame 0xA5
    send(0, 8'hA5, 0, 0, 1, 1'b1);
    capture(8);
    check("t1_done_cnt", done_cnt[0], 1);

    // Parity even / odd on 0x07
    send(1, 8'h07, 1, 0, 1, 1'b1);
    capture(8);
    send(2, 8'h07, 1, 1, 1, 1'b1);
    capture(8);

    // Two stop bits, back to back with tx_valid held high
    align();
    tx_data     = 8'h00;
    tx_valid[3] = 1'b1;
    sb.push_back(mk(3, 8'h00, 0, 0, 2));
    step();
    check("t3_ready_low", tx_ready[3], 0);
    tx_data = 8'hFF;
    sb.push_back(mk(3, 8'hFF, 0, 0, 2));
    capture(8);
    tx_valid[3] = 1'b0;
    capture(5);
    check("t3_done_cnt", done_cnt[3], 2);

    // tx_valid while busy is ignored
    send(0, 8'h81, 0, 0, 1, 1'b1);
    tx_data     = 8'h3C;
    tx_valid[0] = 1'b1;
    check("t4_ready_pre", tx_ready[0], 0);
    step();
    tx_valid[0] = 1'b0;
    check("t4_ready_post", tx_ready[0], 0);
    check("t4_busy_post", tx_busy[0], 1);
    capture(8);
    repeat (12) step();
    check("t4_no_second_busy", tx_busy[0], 0);
    check("t4_no_second_tx", tx_line[0], 1);
    check("t4_done_cnt", done_cnt[0], 2);

    // Accept in a tick cycle: start waits for the following tick
    w = 0;
    while (baud_tick !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    tx_data     = 8'h96;
    tx_valid[0] = 1'b1;
    sb.push_back(mk(0, 8'h96, 0, 0, 1));
    step();
    tx_valid[0] = 1'b0;
    lat = 0;
    while (tx_line[0] !== 1'b0 && lat < 8) begin
      step();
      lat++;
    end
    check("t5_latency", lat, 4);
    capture(0);

    // Reset during data bit 3 abandons the frame
    dc = done_cnt[0];
    send(0, 8'h00, 0, 0, 1, 1'b0);
    w = 0;
    while (tx_line[0] !== 1'b0 && w < 8) begin
      step();
      w++;
    end
    repeat (17) step();
    check("t6_pre_tx", tx_line[0], 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("t6_tx", tx_line[0], 1);
    check("t6_ready", tx_ready[0], 1);
    check("t6_busy", tx_busy[0], 0);
    check("t6_done", tx_done[0], 0);
    repeat (8) step();
    check("t6_no_done", done_cnt[0], dc);
    send(0, 8'h55, 0, 0, 1, 1'b1);
    capture(8);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
